sweep_controller: RTL and testbench
===================================

SWEEP_CONTROLLER -- requirements
Module: sweep_controller

Interface
REQ-001 Clock  input  1  system clock; all state changes on rising edge.
REQ-002 Reset  input  1  asynchronous, active-high reset; forces all registers to reset values immediately.
REQ-003 Start  input  1  sweep start request, sampled on Clock.
REQ-004 Stop  input  1  sweep abort request, sampled on Clock.
REQ-005 Mode  input  2  00 single up-sweep; 01 repeating up-sweep; 10 repeating up/down sweep; 11 treated as 00.
REQ-006 Freq_Start  input  48  first phase-increment value.
REQ-007 Freq_Stop  input  48  final (clamp) phase-increment value.
REQ-008 Freq_Step  input  48  unsigned increment applied per step.
REQ-009 Sweep_Time  input  48  dwell per frequency point, in Clock cycles.
REQ-010 Freq_Out  output  48  current phase increment driven to the DDS accumulator.
REQ-011 Freq_Valid  output  1  one-cycle pulse on every Freq_Out update.
REQ-012 Busy  output  1  high while a sweep is active.
REQ-013 Done  output  1  one-cycle pulse at normal sweep completion.
REQ-014 Marker  output  1  high during up legs, low during down legs and when idle.

Function
REQ-015 States SHALL be IDLE, LOAD, DWELL, STEP, DONE; all outputs registered.
REQ-016 IDLE: Start=1 SHALL move to LOAD; Mode, Freq_Start, Freq_Stop, Freq_Step and Sweep_Time captured in LOAD; input changes during a sweep SHALL be ignored.
REQ-017 Start sampled high at edge k SHALL produce Freq_Out=Freq_Start, Freq_Valid=1, Busy=1, Marker=1 after edge k+2.
REQ-018 Consecutive Freq_Valid pulses SHALL be exactly Sweep_Time cycles apart; Sweep_Time values 0 and 1 SHALL be treated as 2.
REQ-019 Up step: next = Freq_Out + Freq_Step computed at 49 bits; if next >= Freq_Stop or carry out, Freq_Out SHALL be Freq_Stop (end point reached), never wrap.
REQ-020 Down step: next = Freq_Out - Freq_Step; if next <= Freq_Start or borrow, Freq_Out SHALL be Freq_Start (end point reached).
REQ-021 After the dwell of an end point expires: Mode 00/11 SHALL go to DONE; Mode 01 SHALL restart at Freq_Start (Freq_Valid pulse, Marker stays 1); Mode 10 SHALL reverse direction and toggle Marker.
REQ-022 DONE SHALL last one cycle: Done=1, Busy falls on the same edge, Freq_Out holds last value, then IDLE.
REQ-023 Degenerate case (Freq_Step=0 or Freq_Start>=Freq_Stop): Freq_Out=Freq_Start for one dwell, then DONE, for every Mode.
REQ-024 Stop=1 in any non-IDLE state SHALL go to IDLE on the next edge: Busy=0, Marker=0, no Done, Freq_Out holds.
REQ-025 Start and Stop high in the same cycle: Stop SHALL win. Start while Busy SHALL be ignored.
REQ-026 Freq_Valid and Done SHALL never be high longer than one cycle.

Reset
REQ-027 Reset=1 SHALL immediately set state=IDLE, Freq_Out=48'h0, Freq_Valid=0, Busy=0, Done=0, Marker=0, internal counters=0.
REQ-028 Reset mid-sweep SHALL abort without Done; the first Start after release SHALL begin a fresh sweep per REQ-017.

Verification
REQ-029 Mode 00, Start=100, Stop=130, Step=10, Time=4 -> Freq_Out 100,110,120,130 on Valid pulses 4 cycles apart; Done 4 cycles after 130; Busy low.
REQ-030 Step=12, otherwise as REQ-029 -> 100,112,124,130 (clamped), then Done.
REQ-031 Mode 10, as REQ-029 -> 100,110,120,130,120,110,100,110,...; Marker 1 on up values, 0 on down; no Done until Stop.
REQ-032 Start=48'hFFFF_FFFF_FFF0, Stop=48'hFFFF_FFFF_FFFF, Step=48'h20 -> FFF0 then FFFF, no wrap; Time=0 -> pulses 2 cycles apart.
REQ-033 Stop asserted at third Valid of REQ-029 -> next edge Busy=0, Freq_Out=120, no Done; Start+Stop same cycle in IDLE -> no sweep.
REQ-034 Reset asserted mid-DWELL without clock -> outputs zero immediately; Start=130, Stop=100 -> single 130 dwell, Done.

Source files
------------

// File: rtl/sweep_controller.sv
// ---------------------------------------------------------------------------
// sweep_controller
//
// Frequency sweep sequencer for a DDS phase accumulator. A sweep walks the
// phase increment from freq_start towards freq_stop in freq_step increments,
// holding each point for sweep_time clock cycles. The end point is clamped to
// freq_stop (going up) or freq_start (going down) and never wraps.
//
// Sweep modes (captured at sweep start):
//   2'b00 / 2'b11 : single up-sweep, then a one-cycle done pulse
//   2'b01         : repeating up-sweep, restarting at freq_start
//   2'b10         : repeating up/down sweep, reversing at each end point
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   start       in   sweep start request (ignored while busy, loses to stop)
//   stop        in   sweep abort request, returns to idle without done
//   mode[1:0]   in   sweep mode, see above
//   freq_start  in   first phase increment (48 bit)
//   freq_stop   in   final (clamp) phase increment (48 bit)
//   freq_step   in   unsigned increment per step (48 bit)
//   sweep_time  in   dwell per point in clock cycles; 0 and 1 act as 2
//   freq_out    out  current phase increment (48 bit)
//   freq_valid  out  one-cycle pulse on every freq_out update
//   busy        out  high while a sweep is active
//   done        out  one-cycle pulse at normal sweep completion
//   marker      out  high on up legs, low on down legs and when idle
// ---------------------------------------------------------------------------
module sweep_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic [1:0]  mode,
  input  logic [47:0] freq_start,
  input  logic [47:0] freq_stop,
  input  logic [47:0] freq_step,
  input  logic [47:0] sweep_time,
  output logic [47:0] freq_out,
  output logic        freq_valid,
  output logic        busy,
  output logic        done,
  output logic        marker
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DWELL = 3'd2,
    STEP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_REPEAT = 2'b01;

  state_t      state_q, state_d;

  logic [47:0] freq_out_q, freq_out_d;
  logic        freq_valid_q, freq_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        marker_q, marker_d;

  // Sweep parameters, frozen for the whole sweep once captured in LOAD.
  logic [1:0]  mode_cfg_q, mode_cfg_d;
  logic [47:0] start_cfg_q, start_cfg_d;
  logic [47:0] stop_cfg_q, stop_cfg_d;
  logic [47:0] step_cfg_q, step_cfg_d;
  logic [47:0] reload_q, reload_d;

  // Sweep progress.
  logic [47:0] cnt_q, cnt_d;
  logic        dir_up_q, dir_up_d;
  logic        at_end_q, at_end_d;
  logic        first_q, first_d;
  logic        degen_q, degen_d;

  logic [48:0] up_sum;
  logic        up_clamp;
  logic [47:0] down_diff;
  logic        down_clamp;
  logic        go_up;

  // Candidate next points in both directions. The up sum is carried at 49
  // bits so an overflow is detected as a clamp rather than a wrap; a borrow
  // on the way down likewise clamps to the start point.
  always_comb begin
    up_sum     = {1'b0, freq_out_q} + {1'b0, step_cfg_q};
    up_clamp   = up_sum[48] || (up_sum[47:0] >= stop_cfg_q);
    down_diff  = freq_out_q - step_cfg_q;
    down_clamp = (freq_out_q < step_cfg_q) || (down_diff <= start_cfg_q);
  end

  // Next-state and output logic. Every emitted point reloads the dwell
  // counter with (effective dwell - 2): one cycle is the emitting edge itself
  // and one is spent in STEP computing the following point, which keeps the
  // freq_valid pulses exactly one dwell apart. At an end point in up/down
  // mode the direction flips and the first step of the new leg is taken
  // straight away, so the end value is emitted only once per reversal.
  always_comb begin
    state_d      = state_q;
    freq_out_d   = freq_out_q;
    freq_valid_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    marker_d     = marker_q;
    mode_cfg_d   = mode_cfg_q;
    start_cfg_d  = start_cfg_q;
    stop_cfg_d   = stop_cfg_q;
    step_cfg_d   = step_cfg_q;
    reload_d     = reload_q;
    cnt_d        = cnt_q;
    dir_up_d     = dir_up_q;
    at_end_d     = at_end_q;
    first_d      = first_q;
    degen_d      = degen_q;
    go_up        = dir_up_q;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = LOAD;
          busy_d  = 1'b1;
        end
      end

      LOAD: begin
        mode_cfg_d  = (mode == 2'b11) ? MODE_SINGLE : mode;
        start_cfg_d = freq_start;
        stop_cfg_d  = freq_stop;
        step_cfg_d  = freq_step;
        reload_d    = (sweep_time < 48'd2) ? 48'd0 : (sweep_time - 48'd2);
        degen_d     = (freq_step == 48'd0) || (freq_start >= freq_stop);
        first_d     = 1'b1;
        state_d     = STEP;
      end

      STEP: begin
        if (first_q) begin
          freq_out_d   = start_cfg_q;
          freq_valid_d = 1'b1;
          marker_d     = 1'b1;
          dir_up_d     = 1'b1;
          at_end_d     = degen_q;
          first_d      = 1'b0;
          cnt_d        = reload_q;
          state_d      = DWELL;
        end else if (at_end_q && (degen_q || mode_cfg_q == MODE_SINGLE)) begin
          done_d   = 1'b1;
          busy_d   = 1'b0;
          marker_d = 1'b0;
          state_d  = DONE;
        end else if (at_end_q && mode_cfg_q == MODE_REPEAT) begin
          freq_out_d   = start_cfg_q;
          freq_valid_d = 1'b1;
          marker_d     = 1'b1;
          dir_up_d     = 1'b1;
          at_end_d     = 1'b0;
          cnt_d        = reload_q;
          state_d      = DWELL;
        end else begin
          go_up        = at_end_q ? !dir_up_q : dir_up_q;
          dir_up_d     = go_up;
          marker_d     = go_up;
          freq_valid_d = 1'b1;
          cnt_d        = reload_q;
          state_d      = DWELL;
          if (go_up) begin
            freq_out_d = up_clamp ? stop_cfg_q : up_sum[47:0];
            at_end_d   = up_clamp;
          end else begin
            freq_out_d = down_clamp ? start_cfg_q : down_diff;
            at_end_d   = down_clamp;
          end
        end
      end

      DWELL: begin
        if (cnt_q == 48'd0) begin
          state_d = STEP;
        end else begin
          cnt_d = cnt_q - 48'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides whatever the active state decided; freq_out keeps the
    // last emitted point.
    if (stop && state_q != IDLE) begin
      state_d      = IDLE;
      freq_out_d   = freq_out_q;
      freq_valid_d = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      marker_d     = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      freq_out_q   <= 48'h0;
      freq_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      marker_q     <= 1'b0;
      mode_cfg_q   <= 2'b00;
      start_cfg_q  <= 48'h0;
      stop_cfg_q   <= 48'h0;
      step_cfg_q   <= 48'h0;
      reload_q     <= 48'h0;
      cnt_q        <= 48'h0;
      dir_up_q     <= 1'b0;
      at_end_q     <= 1'b0;
      first_q      <= 1'b0;
      degen_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      freq_out_q   <= freq_out_d;
      freq_valid_q <= freq_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      marker_q     <= marker_d;
      mode_cfg_q   <= mode_cfg_d;
      start_cfg_q  <= start_cfg_d;
      stop_cfg_q   <= stop_cfg_d;
      step_cfg_q   <= step_cfg_d;
      reload_q     <= reload_d;
      cnt_q        <= cnt_d;
      dir_up_q     <= dir_up_d;
      at_end_q     <= at_end_d;
      first_q      <= first_d;
      degen_q      <= degen_d;
    end
  end

  assign freq_out   = freq_out_q;
  assign freq_valid = freq_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign marker     = marker_q;

endmodule

// File: tb/tb_sweep_controller.sv
// ---------------------------------------------------------------------------
// tb_sweep_controller
//
// Directed bench for sweep_controller. Inputs are driven and outputs sampled
// on the falling clock edge. Each frequency point is checked for value,
// marker level and the number of cycles since the previous event.
// ---------------------------------------------------------------------------
module tb_sweep_controller;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stop;
  logic [1:0]  mode;
  logic [47:0] freq_start;
  logic [47:0] freq_stop;
  logic [47:0] freq_step;
  logic [47:0] sweep_time;
  logic [47:0] freq_out;
  logic        freq_valid;
  logic        busy;
  logic        done;
  logic        marker;

  int compared;
  int mismatched;

  sweep_controller dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .freq_start (freq_start),
    .freq_stop  (freq_stop),
    .freq_step  (freq_step),
    .sweep_time (sweep_time),
    .freq_out   (freq_out),
    .freq_valid (freq_valid),
    .busy       (busy),
    .done       (done),
    .marker     (marker)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, actual, expected);
    end
  endtask

  // Load sweep parameters.
  task automatic applyStimulus(input logic [1:0] m, input logic [47:0] fs,
                               input logic [47:0] fe, input logic [47:0] st,
                               input logic [47:0] tm);
    mode       = m;
    freq_start = fs;
    freq_stop  = fe;
    freq_step  = st;
    sweep_time = tm;
  endtask

  // One-cycle start request; returns at the negedge where start drops.
  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for the next freq_valid pulse and check value, marker and gap.
  task automatic expectPulse(input string tag, input logic [47:0] expFreq,
                             input logic expMarker, input int expGap);
    int  gap;
    bit  found;
    found = 1'b0;
    gap   = 0;
    for (int i = 1; i <= 100 && !found; i++) begin
      @(negedge clk);
      if (freq_valid) begin
        found = 1'b1;
        gap   = i;
      end
    end
    checkOutput({tag, "_seen"}, found, 1'b1);
    if (found) begin
      checkOutput({tag, "_freq"}, freq_out, expFreq);
      checkOutput({tag, "_marker"}, marker, expMarker);
      checkOutput({tag, "_gap"}, gap, expGap);
    end
  endtask

  // Wait for the done pulse and check its distance from the last point.
  task automatic expectDone(input string tag, input logic [47:0] expFreq,
                            input int expGap);
    int  gap;
    bit  found;
    found = 1'b0;
    gap   = 0;
    for (int i = 1; i <= 100 && !found; i++) begin
      @(negedge clk);
      if (done) begin
        found = 1'b1;
        gap   = i;
      end
    end
    checkOutput({tag, "_seen"}, found, 1'b1);
    if (found) begin
      checkOutput({tag, "_gap"}, gap, expGap);
      checkOutput({tag, "_busy"}, busy, 1'b0);
      checkOutput({tag, "_hold"}, freq_out, expFreq);
      @(negedge clk);
      checkOutput({tag, "_width"}, done, 1'b0);
      checkOutput({tag, "_marker"}, marker, 1'b0);
    end
  endtask

  // Watch a quiet window: no done, no valid, not busy.
  task automatic expectQuiet(input string tag, input int cycles);
    bit sawDone;
    bit sawValid;
    bit sawBusy;
    sawDone  = 1'b0;
    sawValid = 1'b0;
    sawBusy  = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
      if (freq_valid) sawValid = 1'b1;
      if (busy) sawBusy = 1'b1;
    end
    checkOutput({tag, "_noDone"}, sawDone, 1'b0);
    checkOutput({tag, "_noValid"}, sawValid, 1'b0);
    checkOutput({tag, "_noBusy"}, sawBusy, 1'b0);
  endtask

  // Abort at the current negedge and check the state after the next edge.
  task automatic abortSweep(input string tag, input logic [47:0] expFreq);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_marker"}, marker, 1'b0);
    checkOutput({tag, "_hold"}, freq_out, expFreq);
    checkOutput({tag, "_done"}, done, 1'b0);
    expectQuiet(tag, 8);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    start      = 1'b0;
    stop       = 1'b0;
    applyStimulus(2'b00, 48'd0, 48'd0, 48'd0, 48'd0);
    rst = 1'b1;
    #1;
    checkOutput("rst_freq", freq_out, 48'h0);
    checkOutput("rst_valid", freq_valid, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_marker", marker, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Single up-sweep landing exactly on the stop value.
    applyStimulus(2'b00, 48'd100, 48'd130, 48'd10, 48'd4);
    pulseStart();
    expectPulse("m0_p0", 48'd100, 1'b1, 2);
    checkOutput("m0_busy", busy, 1'b1);
    expectPulse("m0_p1", 48'd110, 1'b1, 4);
    expectPulse("m0_p2", 48'd120, 1'b1, 4);
    expectPulse("m0_p3", 48'd130, 1'b1, 4);
    expectDone("m0_done", 48'd130, 4);

    // Mode 11 with a clamped last step; inputs and start are disturbed
    // mid-sweep and must have no effect.
    applyStimulus(2'b11, 48'd100, 48'd130, 48'd12, 48'd4);
    pulseStart();
    expectPulse("m3_p0", 48'd100, 1'b1, 2);
    applyStimulus(2'b10, 48'd5, 48'd500, 48'd1, 48'd9);
    start = 1'b1;
    expectPulse("m3_p1", 48'd112, 1'b1, 4);
    expectPulse("m3_p2", 48'd124, 1'b1, 4);
    start = 1'b0;
    expectPulse("m3_p3", 48'd130, 1'b1, 4);
    expectDone("m3_done", 48'd130, 4);

    // Repeating up/down sweep, ended by stop.
    applyStimulus(2'b10, 48'd100, 48'd130, 48'd10, 48'd4);
    pulseStart();
    expectPulse("m2_p0", 48'd100, 1'b1, 2);
    expectPulse("m2_p1", 48'd110, 1'b1, 4);
    expectPulse("m2_p2", 48'd120, 1'b1, 4);
    expectPulse("m2_p3", 48'd130, 1'b1, 4);
    expectPulse("m2_p4", 48'd120, 1'b0, 4);
    expectPulse("m2_p5", 48'd110, 1'b0, 4);
    expectPulse("m2_p6", 48'd100, 1'b0, 4);
    expectPulse("m2_p7", 48'd110, 1'b1, 4);
    expectPulse("m2_p8", 48'd120, 1'b1, 4);
    abortSweep("m2_stop", 48'd120);

    // Repeating up-sweep restarts at the start value, marker stays high.
    applyStimulus(2'b01, 48'd100, 48'd130, 48'd10, 48'd3);
    pulseStart();
    expectPulse("m1_p0", 48'd100, 1'b1, 2);
    expectPulse("m1_p1", 48'd110, 1'b1, 3);
    expectPulse("m1_p2", 48'd120, 1'b1, 3);
    expectPulse("m1_p3", 48'd130, 1'b1, 3);
    expectPulse("m1_p4", 48'd100, 1'b1, 3);
    expectPulse("m1_p5", 48'd110, 1'b1, 3);
    abortSweep("m1_stop", 48'd110);

    // Top of range: no wrap, zero dwell acts as two cycles.
    applyStimulus(2'b00, 48'hFFFF_FFFF_FFF0, 48'hFFFF_FFFF_FFFF, 48'h20, 48'd0);
    pulseStart();
    expectPulse("top_p0", 48'hFFFF_FFFF_FFF0, 1'b1, 2);
    expectPulse("top_p1", 48'hFFFF_FFFF_FFFF, 1'b1, 2);
    expectDone("top_done", 48'hFFFF_FFFF_FFFF, 2);

    // Stop at the third point of a single sweep.
    applyStimulus(2'b00, 48'd100, 48'd130, 48'd10, 48'd4);
    pulseStart();
    expectPulse("ab_p0", 48'd100, 1'b1, 2);
    expectPulse("ab_p1", 48'd110, 1'b1, 4);
    expectPulse("ab_p2", 48'd120, 1'b1, 4);
    abortSweep("ab_stop", 48'd120);

    // Start and stop together in idle must not start a sweep.
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    checkOutput("ss_busy", busy, 1'b0);
    expectQuiet("ss", 6);

    // Asynchronous reset in the middle of a dwell.
    applyStimulus(2'b10, 48'd100, 48'd130, 48'd10, 48'd8);
    pulseStart();
    expectPulse("ar_p0", 48'd100, 1'b1, 2);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("ar_freq", freq_out, 48'h0);
    checkOutput("ar_valid", freq_valid, 1'b0);
    checkOutput("ar_busy", busy, 1'b0);
    checkOutput("ar_marker", marker, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    expectQuiet("ar", 4);

    // Degenerate range after reset: one dwell at the start value, then done.
    applyStimulus(2'b10, 48'd130, 48'd100, 48'd10, 48'd4);
    pulseStart();
    expectPulse("dg_p0", 48'd130, 1'b1, 2);
    expectDone("dg_done", 48'd130, 4);

    // Zero step is also degenerate, even in repeating mode.
    applyStimulus(2'b01, 48'd100, 48'd130, 48'd0, 48'd1);
    pulseStart();
    expectPulse("zs_p0", 48'd100, 1'b1, 2);
    expectDone("zs_done", 48'd100, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
